// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | Shared 640x480 VGA timing constants, pattern codes and colour types. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_TOTAL   = 800;
  localparam int V_ACTIVE  = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_TOTAL   = 525;
  localparam int BOX_SIZE  = 32;
  localparam int BAR_WIDTH = 80;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_BOX   = 2'd3
  } pattern_e;

  localparam logic [2:0] LVL_OFF  = 3'd0;
  localparam logic [2:0] LVL_HALF = 3'd4;
  localparam logic [2:0] LVL_FULL = 3'd7;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] grn;
    logic [2:0] blu;
  } rgb_t;

  // Comparator chain instead of a divider: highest bar whose left edge is passed.
  function automatic logic [2:0] bar_index(input logic [9:0] col, input int bar_w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(col) >= k * bar_w) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_box_mover.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_box_mover                                                        |
// | Bouncing-box position, one step per frame tick on each axis.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_box_mover #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Tick,
  output logic [9:0] o_X,
  output logic [9:0] o_Y
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic [9:0] MAX_POS = (gi == 0) ? 10'(H_ACTIVE - BOX_SIZE)
                                                 : 10'(V_ACTIVE - BOX_SIZE);
      logic [9:0] r_pos;
      logic       r_neg;

      // At either wall the direction flips and the step is taken the new way.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          r_pos <= 10'd0;
          r_neg <= 1'b0;
        end else if (i_Tick) begin
          if (!r_neg) begin
            if (r_pos == MAX_POS) begin
              r_neg <= 1'b1;
              r_pos <= r_pos - 10'd1;
            end else begin
              r_pos <= r_pos + 10'd1;
            end
          end else begin
            if (r_pos == 10'd0) begin
              r_neg <= 1'b0;
              r_pos <= 10'd1;
            end else begin
              r_pos <= r_pos - 10'd1;
            end
          end
        end
      end
    end
  endgenerate

  assign o_X = g_axis[0].r_pos;
  assign o_Y = g_axis[1].r_pos;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pattern_gen                                                      |
// | Two-stage test-pattern pixel pipeline with sync delay and frame count.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BOX_SIZE  = 32,
  parameter int BAR_WIDTH = 80
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic       i_Active,
  input  logic [9:0] i_Column,
  input  logic [9:0] i_Row,
  input  logic [1:0] i_Pattern_Sel,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [2:0] o_Red,
  output logic [2:0] o_Grn,
  output logic [2:0] o_Blu,
  output logic [7:0] o_Frame_Count
);

  import vga_pkg::*;

  logic [1:0] r_sel_meta;
  logic [1:0] r_sel_sync;

  logic       r_hs1;
  logic       r_vs1;
  logic       r_act1;
  logic [2:0] r_bar1;
  logic       r_chk1;
  logic       r_box1;

  logic       r_hs2;
  logic       r_vs2;
  rgb_t       r_rgb;
  pattern_e   r_pattern;
  logic [7:0] r_frame_cnt;

  logic [9:0]  w_box_x;
  logic [9:0]  w_box_y;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_in_box;
  logic        w_frame_tick;
  rgb_t        w_rgb;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sel_meta <= 2'd0;
      r_sel_sync <= 2'd0;
    end else begin
      r_sel_meta <= i_Pattern_Sel;
      r_sel_sync <= r_sel_meta;
    end
  end

  // 11-bit sums keep the far box edge from wrapping near the bottom/right.
  assign w_x_end  = {1'b0, w_box_x} + 11'(BOX_SIZE);
  assign w_y_end  = {1'b0, w_box_y} + 11'(BOX_SIZE);
  assign w_in_box = (i_Column >= w_box_x) && ({1'b0, i_Column} < w_x_end) &&
                    (i_Row >= w_box_y)    && ({1'b0, i_Row} < w_y_end);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_act1 <= 1'b0;
      r_bar1 <= 3'd0;
      r_chk1 <= 1'b0;
      r_box1 <= 1'b0;
    end else begin
      r_hs1  <= i_HSync;
      r_vs1  <= i_VSync;
      r_act1 <= i_Active;
      r_bar1 <= bar_index(i_Column, BAR_WIDTH);
      r_chk1 <= i_Column[5] ^ i_Row[5];
      r_box1 <= w_in_box;
    end
  end

  // r_vs2 is the previous r_vs1 sample, so this fires once per vsync fall.
  assign w_frame_tick = r_vs2 & ~r_vs1;

  always_comb begin
    w_rgb = '0;
    if (r_act1) begin
      case (r_pattern)
        PAT_SOLID: w_rgb.grn = LVL_FULL;
        PAT_BARS: begin
          w_rgb.red = {3{r_bar1[2]}};
          w_rgb.grn = {3{r_bar1[1]}};
          w_rgb.blu = {3{r_bar1[0]}};
        end
        PAT_CHECK: begin
          if (r_chk1) w_rgb = '{LVL_FULL, LVL_FULL, LVL_FULL};
        end
        PAT_BOX: begin
          if (r_box1) w_rgb = '{LVL_FULL, LVL_FULL, LVL_FULL};
          else        w_rgb.blu = LVL_HALF;
        end
        default: w_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_hs2       <= 1'b1;
      r_vs2       <= 1'b1;
      r_rgb       <= '0;
      r_pattern   <= PAT_SOLID;
      r_frame_cnt <= 8'd0;
    end else begin
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_rgb <= w_rgb;
      if (w_frame_tick) begin
        r_pattern   <= pattern_e'(r_sel_sync);
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE)
  ) u_box_mover (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Tick  (w_frame_tick),
    .o_X     (w_box_x),
    .o_Y     (w_box_y)
  );

  assign o_HSync       = r_hs2;
  assign o_VSync       = r_vs2;
  assign o_Red         = r_rgb.red;
  assign o_Grn         = r_rgb.grn;
  assign o_Blu         = r_rgb.blu;
  assign o_Frame_Count = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_pattern_gen                                                   |
// | Directed vector table plus hand sequences for vga_pattern_gen.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic       act = 1'b0;
  logic [9:0] col = 10'd0;
  logic [9:0] row = 10'd0;
  logic [1:0] sel = 2'd1;
  logic       o_hs, o_vs;
  logic [2:0] o_r, o_g, o_b;
  logic [7:0] o_fc;

  int errors = 0;
  int checks = 0;
  int n_frames = 0;

  always #20 clk = ~clk;

  vga_pattern_gen dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_HSync       (hs),
    .i_VSync       (vs),
    .i_Active      (act),
    .i_Column      (col),
    .i_Row         (row),
    .i_Pattern_Sel (sel),
    .o_HSync       (o_hs),
    .o_VSync       (o_vs),
    .o_Red         (o_r),
    .o_Grn         (o_g),
    .o_Blu         (o_b),
    .o_Frame_Count (o_fc)
  );

  typedef struct {
    logic [1:0] sel;
    logic [9:0] col;
    logic [9:0] row;
    logic       act;
    logic [8:0] rgb;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d (o%0o) expected %0d (o%0o)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic int rgb_now();
    return int'({o_r, o_g, o_b});
  endfunction

  task automatic px(input int c, input int r, input logic a, input logic [8:0] exp, input string name);
    @(negedge clk);
    col = 10'(c); row = 10'(r); act = a; hs = 1'b1; vs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(name, rgb_now(), int'(exp));
  endtask

  task automatic frame_tick();
    @(negedge clk);
    act = 1'b0; vs = 1'b0;
    repeat (3) @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
    n_frames++;
  endtask

  task automatic set_sel(input logic [1:0] v);
    @(negedge clk);
    sel = v;
    repeat (3) @(negedge clk);
  endtask

  // Triangle-wave reference for the bouncing box.
  function automatic int tri_pos(input int n, input int maxp);
    int p;
    p = n % (2 * maxp);
    return (p <= maxp) ? p : (2 * maxp - p);
  endfunction

  task automatic check_box();
    int x, y;
    x = tri_pos(n_frames, 608);
    y = tri_pos(n_frames, 448);
    px(x, y, 1'b1, 9'o777, "box_in_tl");
    px(x + 31, y + 31, 1'b1, 9'o777, "box_in_br");
    px(x + 32, y, 1'b1, 9'o004, "box_out_r");
    px(x, y + 32, 1'b1, 9'o004, "box_out_b");
    chk("box_frame_count", int'(o_fc), n_frames % 256);
  endtask

  function automatic logic [8:0] stream_rgb(input int c);
    logic [9:0] cv;
    cv = 10'(c);
    if (c >= 640) return 9'o000;
    return cv[5] ? 9'o777 : 9'o000;
  endfunction

  function automatic int stream_hs(input int c);
    return (c >= 656 && c < 752) ? 0 : 1;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int cps[6];

    vecs[0]  = '{2'd1, 10'd85,  10'd10,  1'b1, 9'o007};
    vecs[1]  = '{2'd1, 10'd600, 10'd10,  1'b1, 9'o777};
    vecs[2]  = '{2'd1, 10'd79,  10'd0,   1'b1, 9'o000};
    vecs[3]  = '{2'd1, 10'd80,  10'd0,   1'b1, 9'o007};
    vecs[4]  = '{2'd1, 10'd160, 10'd0,   1'b1, 9'o070};
    vecs[5]  = '{2'd1, 10'd240, 10'd0,   1'b1, 9'o077};
    vecs[6]  = '{2'd1, 10'd320, 10'd0,   1'b1, 9'o700};
    vecs[7]  = '{2'd1, 10'd639, 10'd479, 1'b1, 9'o777};
    vecs[8]  = '{2'd1, 10'd700, 10'd10,  1'b0, 9'o000};
    vecs[9]  = '{2'd2, 10'd0,   10'd0,   1'b1, 9'o000};
    vecs[10] = '{2'd2, 10'd32,  10'd0,   1'b1, 9'o777};
    vecs[11] = '{2'd2, 10'd32,  10'd32,  1'b1, 9'o000};
    vecs[12] = '{2'd2, 10'd0,   10'd32,  1'b1, 9'o777};
    vecs[13] = '{2'd2, 10'd31,  10'd0,   1'b1, 9'o000};
    vecs[14] = '{2'd2, 10'd700, 10'd0,   1'b0, 9'o000};
    vecs[15] = '{2'd0, 10'd5,   10'd5,   1'b1, 9'o070};
    vecs[16] = '{2'd0, 10'd100, 10'd479, 1'b1, 9'o070};
    vecs[17] = '{2'd0, 10'd650, 10'd0,   1'b0, 9'o000};

    // Reset and reset-state outputs
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", int'(o_hs), 1);
    chk("rst_vsync", int'(o_vs), 1);
    chk("rst_rgb", rgb_now(), 0);
    chk("rst_frame_count", int'(o_fc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Select=1 is ignored until the first frame tick
    px(85, 10, 1'b1, 9'o070, "pre_tick_solid_85");
    px(600, 10, 1'b1, 9'o070, "pre_tick_solid_600");
    frame_tick();
    chk("first_tick_count", int'(o_fc), 1);
    px(85, 10, 1'b1, 9'o007, "bars_85");
    px(600, 10, 1'b1, 9'o777, "bars_600");

    cur = 1;
    for (int i = 0; i < 18; i++) begin
      if (int'(vecs[i].sel) != cur) begin
        set_sel(vecs[i].sel);
        frame_tick();
        cur = int'(vecs[i].sel);
      end
      px(int'(vecs[i].col), int'(vecs[i].row), vecs[i].act, vecs[i].rgb, $sformatf("vec%0d", i));
    end

    // Sync/RGB alignment across the end of the active line
    set_sel(2'd2);
    frame_tick();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      col = 10'(636 + k); row = 10'd0; act = (636 + k) < 640;
      hs = 1'(stream_hs(636 + k)); vs = 1'b1;
      @(posedge clk);
      #1;
      if (k >= 1) begin
        chk($sformatf("align_hs_c%0d", 635 + k), int'(o_hs), stream_hs(635 + k));
        chk($sformatf("align_rgb_c%0d", 635 + k), rgb_now(), int'(stream_rgb(635 + k)));
      end
    end

    // Select change mid-frame only takes effect on the next vsync fall
    @(negedge clk);
    hs = 1'b1;
    px(40, 200, 1'b1, 9'o777, "midframe_check_before");
    set_sel(2'd1);
    px(40, 200, 1'b1, 9'o777, "midframe_still_check");
    repeat (10) @(negedge clk);
    px(40, 200, 1'b1, 9'o777, "midframe_still_check_later");
    @(negedge clk);
    vs = 1'b0;
    @(posedge clk); #1;
    chk("sel_hold_p0", rgb_now(), 9'o777);
    @(posedge clk); #1;
    chk("sel_hold_p1", rgb_now(), 9'o777);
    @(posedge clk); #1;
    chk("sel_apply_p2", rgb_now(), 9'o000);
    @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
    n_frames++;
    chk("midframe_count", int'(o_fc), n_frames % 256);

    // Frame counter wrap
    while (n_frames % 256 != 255) frame_tick();
    chk("count_255", int'(o_fc), 255);
    frame_tick();
    chk("count_wrap_0", int'(o_fc), 0);

    // Bouncing box at the reversal frames
    set_sel(2'd3);
    frame_tick();
    check_box();
    cps = '{448, 449, 608, 609, 1216, 1217};
    for (int j = 0; j < 6; j++) begin
      while (n_frames < cps[j]) frame_tick();
      check_box();
    end

    // Asynchronous reset mid-frame with the box pattern showing
    @(negedge clk);
    col = 10'd100; row = 10'd300; act = 1'b1; hs = 1'b0; vs = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_hsync_low", int'(o_hs), 0);
    chk("pre_rst_rgb_bg", rgb_now(), 9'o004);
    #5 rst_n = 1'b0;
    #1;
    chk("midrst_rgb", rgb_now(), 0);
    chk("midrst_hsync", int'(o_hs), 1);
    chk("midrst_vsync", int'(o_vs), 1);
    chk("midrst_count", int'(o_fc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_frames = 0;
    px(100, 300, 1'b1, 9'o070, "post_rst_solid");
    frame_tick();
    check_box();
    px(0, 0, 1'b1, 9'o004, "post_rst_box_origin_outside");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
